// File: rtl/julia_scheduler.sv
// julia_scheduler
// ---------------------------------------------------------------------------
// Frame-level scheduler that sits between the parameter-entry front end and
// a bank of NUM_CORES Julia iteration cores.
//
// On start it captures the Julia constant, the top-left z corner and the
// pixel pitch. It then walks the raster left-to-right, top-to-bottom and
// hands one pixel per cycle to an idle core, choosing cores round-robin.
// Finished iteration counts are collected round-robin into a one-entry
// output register. That register drives the frame-buffer write port.
//
// Ports
//   clock, reset          : system clock, synchronous active-high reset
//   start                 : one-cycle frame request (ignored while busy)
//   c_real, c_comp        : Julia constant, signed 4.14
//   z_real, z_comp        : top-left pixel coordinate, signed 4.14
//   z_scale               : pixel pitch, 4.14
//   busy, frame_done      : frame in progress / one-cycle completion pulse
//   core_ready            : per-core idle flags
//   core_start            : one-hot dispatch pulse
//   core_c_*, core_z_*    : shared dispatch operands (valid with core_start)
//   core_done, core_iter  : per-core result flag and packed iteration counts
//   core_ack              : one-hot result acknowledge pulse
//   fb_we, fb_addr, fb_data, fb_ready : frame-buffer write port
//
// Every output is driven directly from a flop. Dispatch and collection
// decisions are therefore visible one cycle after they are made. A core keeps
// its old ready/done level for the cycle in which our start/ack pulse is on
// the wire. Both pulses are used to mask the stale flag for that cycle.
// ---------------------------------------------------------------------------
module julia_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int ITER_W    = 8,
    parameter int ADDR_W    = 19
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [17:0]                 c_real,
    input  logic [17:0]                 c_comp,
    input  logic [17:0]                 z_real,
    input  logic [17:0]                 z_comp,
    input  logic [17:0]                 z_scale,
    output logic                        busy,
    output logic                        frame_done,
    input  logic [NUM_CORES-1:0]        core_ready,
    output logic [NUM_CORES-1:0]        core_start,
    output logic [17:0]                 core_c_real,
    output logic [17:0]                 core_c_comp,
    output logic [17:0]                 core_z_real,
    output logic [17:0]                 core_z_comp,
    input  logic [NUM_CORES-1:0]        core_done,
    input  logic [NUM_CORES*ITER_W-1:0] core_iter,
    output logic [NUM_CORES-1:0]        core_ack,
    output logic                        fb_we,
    output logic [ADDR_W-1:0]           fb_addr,
    output logic [ITER_W-1:0]           fb_data,
    input  logic                        fb_ready
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int X_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W   = (V_RES > 1) ? $clog2(V_RES) : 1;

    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Round-robin pointer arithmetic: base + off, wrapped into 0..NUM_CORES-1.
    // off never exceeds NUM_CORES-1, so one subtraction is enough.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base,
                                                 input int               off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_CORES) begin
            sum = sum - NUM_CORES;
        end else begin
            sum = sum;
        end
        return PTR_W'(sum);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q,        state_d;
    logic                   busy_q,         busy_d;
    logic                   frame_done_q,   frame_done_d;

    logic [17:0]            c_real_q,       c_real_d;
    logic [17:0]            c_comp_q,       c_comp_d;
    logic [17:0]            z_real_q,       z_real_d;
    logic [17:0]            z_scale_q,      z_scale_d;

    logic [17:0]            cur_zr_q,       cur_zr_d;
    logic [17:0]            cur_zi_q,       cur_zi_d;
    logic [X_W-1:0]         x_q,            x_d;
    logic [Y_W-1:0]         y_q,            y_d;
    logic [ADDR_W-1:0]      addr_q,         addr_d;
    logic                   all_disp_q,     all_disp_d;

    logic [PTR_W-1:0]       dpt_q,          dpt_d;
    logic [PTR_W-1:0]       cpt_q,          cpt_d;
    logic [ADDR_W-1:0]      tag_q [NUM_CORES];
    logic [ADDR_W-1:0]      tag_d [NUM_CORES];

    logic [NUM_CORES-1:0]   core_start_q,   core_start_d;
    logic [NUM_CORES-1:0]   core_ack_q,     core_ack_d;
    logic [17:0]            core_c_real_q,  core_c_real_d;
    logic [17:0]            core_c_comp_q,  core_c_comp_d;
    logic [17:0]            core_z_real_q,  core_z_real_d;
    logic [17:0]            core_z_comp_q,  core_z_comp_d;

    logic                   fb_we_q,        fb_we_d;
    logic [ADDR_W-1:0]      fb_addr_q,      fb_addr_d;
    logic [ITER_W-1:0]      fb_data_q,      fb_data_d;

    // ------------------------------------------------------------------
    // Arbitration inputs
    // ------------------------------------------------------------------
    logic [NUM_CORES-1:0]   disp_avail_s;
    logic [NUM_CORES-1:0]   coll_avail_s;
    logic                   disp_found_s;
    logic [PTR_W-1:0]       disp_sel_s;
    logic                   coll_found_s;
    logic [PTR_W-1:0]       coll_sel_s;
    logic                   out_free_s;
    logic                   dispatch_en_s;
    logic                   load_en_s;
    logic                   complete_s;

    // A core that is being started or acked right now still shows its old
    // ready/done level. Hide that core for this cycle.
    assign disp_avail_s = core_ready & ~core_start_q;
    assign coll_avail_s = core_done  & ~core_ack_q;

    // The output register can take a new entry when it is empty, or when
    // its current entry is written this cycle.
    assign out_free_s = ~fb_we_q | fb_ready;

    // Round-robin search for the next idle core, starting at dpt.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx          = '0;
        disp_found_s = 1'b0;
        disp_sel_s   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx          = ptr_add(dpt_q, k);
            disp_sel_s   = (!disp_found_s && disp_avail_s[idx]) ? idx : disp_sel_s;
            disp_found_s = disp_found_s | disp_avail_s[idx];
        end
    end

    // Round-robin search for the next finished core, starting at cpt.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx          = '0;
        coll_found_s = 1'b0;
        coll_sel_s   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx          = ptr_add(cpt_q, k);
            coll_sel_s   = (!coll_found_s && coll_avail_s[idx]) ? idx : coll_sel_s;
            coll_found_s = coll_found_s | coll_avail_s[idx];
        end
    end

    assign dispatch_en_s = (state_q == ST_RUN) && !all_disp_q && disp_found_s;
    assign load_en_s     = (state_q == ST_RUN) && coll_found_s && out_free_s;

    // The frame is finished when every pixel is out, no result is pending,
    // every core is idle, no start pulse is in flight, and the output
    // register is empty or draining this cycle.
    assign complete_s = (state_q == ST_RUN) && all_disp_q &&
                        (core_done == '0) && (&core_ready) &&
                        (core_start_q == '0) && out_free_s;

    // Next-state logic for the frame FSM, raster walker and output register.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        frame_done_d  = 1'b0;
        c_real_d      = c_real_q;
        c_comp_d      = c_comp_q;
        z_real_d      = z_real_q;
        z_scale_d     = z_scale_q;
        cur_zr_d      = cur_zr_q;
        cur_zi_d      = cur_zi_q;
        x_d           = x_q;
        y_d           = y_q;
        addr_d        = addr_q;
        all_disp_d    = all_disp_q;
        dpt_d         = dpt_q;
        cpt_d         = cpt_q;
        for (int i = 0; i < NUM_CORES; i++) begin
            tag_d[i] = tag_q[i];
        end
        core_start_d  = '0;
        core_ack_d    = '0;
        core_c_real_d = core_c_real_q;
        core_c_comp_d = core_c_comp_q;
        core_z_real_d = core_z_real_q;
        core_z_comp_d = core_z_comp_q;
        fb_we_d       = fb_we_q;
        fb_addr_d     = fb_addr_q;
        fb_data_d     = fb_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    c_real_d   = c_real;
                    c_comp_d   = c_comp;
                    z_real_d   = z_real;
                    z_scale_d  = z_scale;
                    cur_zr_d   = z_real;
                    cur_zi_d   = z_comp;
                    x_d        = '0;
                    y_d        = '0;
                    addr_d     = '0;
                    all_disp_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_RUN;
                end else begin
                    state_d    = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (dispatch_en_s) begin
                    core_start_d          = NUM_CORES'(1) << disp_sel_s;
                    core_c_real_d         = c_real_q;
                    core_c_comp_d         = c_comp_q;
                    core_z_real_d         = cur_zr_q;
                    core_z_comp_d         = cur_zi_q;
                    tag_d[disp_sel_s]     = addr_q;
                    dpt_d                 = ptr_add(disp_sel_s, 1);
                    addr_d                = addr_q + ADDR_W'(1);
                    if (x_q != X_LAST) begin
                        x_d      = x_q + X_W'(1);
                        cur_zr_d = cur_zr_q + z_scale_q;
                    end else begin
                        // Row wrap: back to the left edge, one pitch down.
                        x_d        = '0;
                        y_d        = y_q + Y_W'(1);
                        cur_zr_d   = z_real_q;
                        cur_zi_d   = cur_zi_q - z_scale_q;
                        all_disp_d = (y_q == Y_LAST);
                    end
                end else begin
                    core_start_d = '0;
                end

                if (complete_s) begin
                    state_d      = ST_IDLE;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end else begin
                    state_d      = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Output register. It loads a new result or drains the current one.
        if (load_en_s) begin
            core_ack_d = NUM_CORES'(1) << coll_sel_s;
            cpt_d      = ptr_add(coll_sel_s, 1);
            fb_we_d    = 1'b1;
            fb_addr_d  = tag_q[coll_sel_s];
            fb_data_d  = core_iter[int'(coll_sel_s)*ITER_W +: ITER_W];
        end else if (fb_ready) begin
            fb_we_d    = 1'b0;
        end else begin
            fb_we_d    = fb_we_q;
        end
    end

    // All state and registered outputs, with synchronous reset to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            c_real_q      <= '0;
            c_comp_q      <= '0;
            z_real_q      <= '0;
            z_scale_q     <= '0;
            cur_zr_q      <= '0;
            cur_zi_q      <= '0;
            x_q           <= '0;
            y_q           <= '0;
            addr_q        <= '0;
            all_disp_q    <= 1'b0;
            dpt_q         <= '0;
            cpt_q         <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                tag_q[i]  <= '0;
            end
            core_start_q  <= '0;
            core_ack_q    <= '0;
            core_c_real_q <= '0;
            core_c_comp_q <= '0;
            core_z_real_q <= '0;
            core_z_comp_q <= '0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            c_real_q      <= c_real_d;
            c_comp_q      <= c_comp_d;
            z_real_q      <= z_real_d;
            z_scale_q     <= z_scale_d;
            cur_zr_q      <= cur_zr_d;
            cur_zi_q      <= cur_zi_d;
            x_q           <= x_d;
            y_q           <= y_d;
            addr_q        <= addr_d;
            all_disp_q    <= all_disp_d;
            dpt_q         <= dpt_d;
            cpt_q         <= cpt_d;
            for (int i = 0; i < NUM_CORES; i++) begin
                tag_q[i]  <= tag_d[i];
            end
            core_start_q  <= core_start_d;
            core_ack_q    <= core_ack_d;
            core_c_real_q <= core_c_real_d;
            core_c_comp_q <= core_c_comp_d;
            core_z_real_q <= core_z_real_d;
            core_z_comp_q <= core_z_comp_d;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_data_q     <= fb_data_d;
        end
    end

    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign core_start  = core_start_q;
    assign core_ack    = core_ack_q;
    assign core_c_real = core_c_real_q;
    assign core_c_comp = core_c_comp_q;
    assign core_z_real = core_z_real_q;
    assign core_z_comp = core_z_comp_q;
    assign fb_we       = fb_we_q;
    assign fb_addr     = fb_addr_q;
    assign fb_data     = fb_data_q;

endmodule

// File: tb/tb_julia_scheduler.sv
// Directed testbench for julia_scheduler on a 4x2 raster with four
// behavioural cores of fixed 3-cycle latency.
module tb_julia_scheduler;

    localparam int NC = 4;
    localparam int HR = 4;
    localparam int VR = 2;
    localparam int IW = 8;
    localparam int AW = 19;

    localparam logic [17:0] ZR0 = 18'h38000;   // -2.0
    localparam logic [17:0] ZI0 = 18'h04000;   //  1.0
    localparam logic [17:0] SC  = 18'h02000;   //  0.5
    localparam logic [17:0] CR  = 18'h00123;
    localparam logic [17:0] CI  = 18'h3FF45;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [17:0]       c_real, c_comp, z_real, z_comp, z_scale;
    logic              busy, frame_done;
    logic [NC-1:0]     core_ready, core_start, core_done, core_ack;
    logic [17:0]       core_c_real, core_c_comp, core_z_real, core_z_comp;
    logic [NC*IW-1:0]  core_iter;
    logic              fb_we, fb_ready;
    logic [AW-1:0]     fb_addr;
    logic [IW-1:0]     fb_data;

    // Core models, plus a forced mode for the reset and ack-order steps.
    logic [NC-1:0]     m_ready, m_done;
    logic [IW-1:0]     m_iter [NC];
    int                m_cnt  [NC];
    logic              force_en;
    logic [NC-1:0]     force_ready, force_done;

    assign core_ready = force_en ? force_ready : m_ready;
    assign core_done  = force_en ? force_done  : m_done;
    assign core_iter  = {m_iter[3], m_iter[2], m_iter[1], m_iter[0]};

    // Logs, written only by the monitor and indexed by frame id.
    int                fid;
    int                disp_n [8];
    logic [NC-1:0]     disp_oh [8][16];
    logic [17:0]       disp_zr [8][16];
    logic [17:0]       disp_zi [8][16];
    int                wr_n   [8][8];
    logic [IW-1:0]     wr_d   [8][8];
    int                ack_n  [8];
    logic [NC-1:0]     ack_oh [8][16];

    int checks = 0;
    int errors = 0;

    julia_scheduler #(.NUM_CORES(NC), .H_RES(HR), .V_RES(VR), .ITER_W(IW), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .c_real(c_real), .c_comp(c_comp), .z_real(z_real), .z_comp(z_comp), .z_scale(z_scale),
        .busy(busy), .frame_done(frame_done),
        .core_ready(core_ready), .core_start(core_start),
        .core_c_real(core_c_real), .core_c_comp(core_c_comp),
        .core_z_real(core_z_real), .core_z_comp(core_z_comp),
        .core_done(core_done), .core_iter(core_iter), .core_ack(core_ack),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [IW-1:0] iter_of(input logic [17:0] zr, input logic [17:0] zi,
                                              input logic [17:0] cr, input logic [17:0] ci);
        return zr[17:10] + zi[17:10] + cr[7:0] + ci[7:0];
    endfunction

    function automatic logic [17:0] exp_zr(input int k);
        return ZR0 + 18'(k % HR) * SC;
    endfunction

    function automatic logic [17:0] exp_zi(input int k);
        return ZI0 - 18'(k / HR) * SC;
    endfunction

    // Behavioural cores: start -> busy 3 cycles -> done held until ack.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NC; i++) begin
                m_ready[i] <= 1'b1;
                m_done[i]  <= 1'b0;
                m_cnt[i]   <= 0;
                m_iter[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (core_start[i]) begin
                    m_ready[i] <= 1'b0;
                    m_cnt[i]   <= 3;
                    m_iter[i]  <= iter_of(core_z_real, core_z_comp, core_c_real, core_c_comp);
                end else if (m_cnt[i] != 0) begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    if (m_cnt[i] == 1) m_done[i] <= 1'b1;
                end
                if (core_ack[i]) begin
                    m_done[i]  <= 1'b0;
                    m_ready[i] <= 1'b1;
                end
            end
        end
    end

    // Monitor: record dispatches, completed writes and acks per frame.
    always @(posedge clock) begin
        if (core_start != '0 && disp_n[fid] < 16) begin
            disp_oh[fid][disp_n[fid]] <= core_start;
            disp_zr[fid][disp_n[fid]] <= core_z_real;
            disp_zi[fid][disp_n[fid]] <= core_z_comp;
            disp_n[fid]               <= disp_n[fid] + 1;
        end
        if (fb_we && fb_ready && fb_addr < 19'd8) begin
            wr_n[fid][fb_addr[2:0]] <= wr_n[fid][fb_addr[2:0]] + 1;
            wr_d[fid][fb_addr[2:0]] <= fb_data;
        end
        if (core_ack != '0 && ack_n[fid] < 16) begin
            ack_oh[fid][ack_n[fid]] <= core_ack;
            ack_n[fid]              <= ack_n[fid] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!frame_done && t < 400) begin
            @(negedge clock);
            t++;
        end
        check("frame_done_seen", {31'd0, frame_done}, 32'd1);
    endtask

    task automatic wait_disp(input int f, input int n);
        int t = 0;
        while (disp_n[f] < n && t < 200) begin
            @(negedge clock);
            t++;
        end
        check($sformatf("dispatch_reach_%0d", n), {31'd0, disp_n[f] >= n}, 32'd1);
    endtask

    task automatic check_frame(input int f);
        for (int a = 0; a < HR*VR; a++) begin
            check($sformatf("f%0d_wr_count[%0d]", f, a), wr_n[f][a], 32'd1);
            check($sformatf("f%0d_wr_data[%0d]", f, a), {24'd0, wr_d[f][a]},
                  {24'd0, iter_of(exp_zr(a), exp_zi(a), CR, CI)});
        end
    endtask

    initial begin
        logic [AW-1:0] hold_a;
        logic [IW-1:0] hold_d;
        int t;

        // Reset with start and every core_done asserted.
        fid = 0; reset = 1'b1; start = 1'b1; fb_ready = 1'b1;
        force_en = 1'b1; force_ready = 4'hF; force_done = 4'hF;
        c_real = CR; c_comp = CI; z_real = ZR0; z_comp = ZI0; z_scale = SC;
        repeat (2) @(negedge clock);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_core_start", {28'd0, core_start}, 32'd0);
        check("rst_core_ack",   {28'd0, core_ack},   32'd0);
        check("rst_fb_we",      {31'd0, fb_we},      32'd0);
        check("rst_fb_addr",    {13'd0, fb_addr},    32'd0);
        check("rst_fb_data",    {24'd0, fb_data},    32'd0);
        check("rst_core_zr",    {14'd0, core_z_real}, 32'd0);
        check("rst_core_cr",    {14'd0, core_c_real}, 32'd0);
        reset = 1'b0; start = 1'b0; force_en = 1'b0;
        @(negedge clock);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Frame 1: clean raster walk, round-robin and completion.
        fid = 1;
        pulse_start();
        check("f1_busy_after_start", {31'd0, busy}, 32'd1);
        wait_done();
        check("f1_busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clock);
        check("f1_done_one_cycle", {31'd0, frame_done}, 32'd0);
        check_frame(1);
        check("f1_disp_count", disp_n[1], 32'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("f1_start_onehot[%0d]", k), {28'd0, disp_oh[1][k]}, 32'd1 << (k % NC));
            check($sformatf("f1_zr[%0d]", k), {14'd0, disp_zr[1][k]}, {14'd0, exp_zr(k)});
            check($sformatf("f1_zi[%0d]", k), {14'd0, disp_zi[1][k]}, {14'd0, exp_zi(k)});
        end

        // Frame 2: starts one cycle after frame_done, with 10 cycles of backpressure.
        fid = 2;
        pulse_start();
        t = 0;
        while (!fb_we && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("f2_fb_we_seen", {31'd0, fb_we}, 32'd1);
        fb_ready = 1'b0;
        hold_a = fb_addr;
        hold_d = fb_data;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check($sformatf("bp_we[%0d]", k),   {31'd0, fb_we},   32'd1);
            check($sformatf("bp_addr[%0d]", k), {13'd0, fb_addr}, {13'd0, hold_a});
            check($sformatf("bp_data[%0d]", k), {24'd0, fb_data}, {24'd0, hold_d});
            check($sformatf("bp_ack[%0d]", k),  {28'd0, core_ack}, 32'd0);
        end
        fb_ready = 1'b1;
        wait_done();
        check_frame(2);
        check("f2_first_zr", {14'd0, disp_zr[2][0]}, {14'd0, ZR0});

        // Frame 3: start and new c mid-frame must be ignored.
        @(negedge clock);
        fid = 3;
        pulse_start();
        wait_disp(3, 3);
        c_real = 18'h01000;
        pulse_start();
        check("f3_busy_hold", {31'd0, busy}, 32'd1);
        wait_done();
        check_frame(3);
        check("f3_disp_count", disp_n[3], 32'd8);
        c_real = CR;

        // Frame 4: reset after the fifth pixel is dispatched.
        @(negedge clock);
        fid = 4;
        pulse_start();
        wait_disp(4, 5);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_busy",       {31'd0, busy},       32'd0);
        check("midrst_fb_we",      {31'd0, fb_we},      32'd0);
        check("midrst_core_start", {28'd0, core_start}, 32'd0);
        check("midrst_core_ack",   {28'd0, core_ack},   32'd0);

        // Frame 5: clean frame after the mid-frame reset.
        @(negedge clock);
        fid = 5;
        pulse_start();
        wait_done();
        check_frame(5);
        check("f5_disp_count", disp_n[5], 32'd8);

        // Frame 6: all done together, no core ready -> acks 0,1,2,3.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        force_en = 1'b1; force_ready = 4'h0; force_done = 4'hF;
        fid = 6;
        pulse_start();
        repeat (8) @(negedge clock);
        check("f6_ack_count_ge4", {31'd0, ack_n[6] >= 4}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("f6_ack_onehot[%0d]", k), {28'd0, ack_oh[6][k]}, 32'd1 << k);
        end
        check("f6_no_dispatch", disp_n[6], 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        force_en = 1'b0;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
